universal_shift_register: RTL and testbench
===========================================

Name: universal_shift_register

Overview:
Parametrised successor to the single-bit right shift register. Holds DEPTH stages of WIDTH-bit symbols with a per-cycle operation select: hold, shift right/left, rotate right/left, parallel load, clear. Tracks how many stages hold valid data and flags when a valid symbol is shifted out. Used in serialisers, deserialisers and delay lines in the shifting library.

Parameters:
WIDTH, 1, bits per symbol (>=1)
DEPTH, 8, number of stages (>=2)
CW, $clog2(DEPTH+1), width of fill counter (derived, do not override)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
enable  input  1  operation enable; 0 = hold regardless of mode
mode  input  3  operation select, see Behaviour
serial_in  input  WIDTH  symbol entering on shift
parallel_in  input  DEPTH*WIDTH  load data, stage i = bits [(i+1)*WIDTH-1 : i*WIDTH]
out  output  DEPTH*WIDTH  register contents, same stage packing
serial_out  output  WIDTH  last symbol ejected by a shift (registered)
serial_out_valid  output  1  1-cycle pulse: serial_out is an ejected valid symbol
fill  output  CW  count of valid stages, 0..DEPTH
full  output  1  fill == DEPTH

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Ports named clk and reset.
- Reset (reset==0 at rising edge): out=0, serial_out=0, serial_out_valid=0, fill=0, full=0. Dominates enable and mode.
- enable==0: all state held; serial_out_valid forced 0 next cycle; serial_out held.
- Modes (enable==1), stage 0 = least-significant symbol:
  000 hold: no change.
  001 shift right: stage DEPTH-1 <= serial_in; stage i <= stage i+1; ejected symbol = old stage 0.
  010 shift left: stage 0 <= serial_in; stage i <= stage i-1; ejected symbol = old stage DEPTH-1.
  011 rotate right: stage DEPTH-1 <= old stage 0; others as shift right.
  100 rotate left: stage 0 <= old stage DEPTH-1; others as shift left.
  101 parallel load: out <= parallel_in.
  110 clear: out <= 0.
  111 reserved: behaves as hold.
- Shift right with WIDTH=1 reproduces the previous block: new bit enters MSB.
- serial_out: updated only on shift modes (001/010) with ejected symbol; otherwise held.
- serial_out_valid: 1 for one cycle after a shift where fill==DEPTH before the shift; else 0. Rotate, load, clear, hold give 0.
- fill: shift -> min(fill+1, DEPTH) (saturates); load -> DEPTH; clear -> 0; rotate/hold/reserved -> unchanged.
- full combinational from registered fill; no other combinational paths from inputs to outputs.
- Latency: all outputs reflect an operation one clock after the sampling edge.
- Reset in the same cycle as any mode: reset result only.

Test Plan:
1. Hold reset low 1 cycle with mode=101, parallel_in all ones -> out=0, fill=0, full=0, serial_out=0, serial_out_valid=0.
2. WIDTH=1, DEPTH=8, mode=001, feed 1,1,0,1,0,1,1 -> out=8'b11010110, fill=7, full=0; shift in 0 -> out=8'b01101011, fill=8, full=1, serial_out=0, valid=0; shift in 0 -> out=8'b00110101, serial_out=1, valid=1.
3. Load 8'hA5 (mode=101) -> fill=8; rotate left -> 8'h4B; rotate right twice -> 8'hD2; fill stays 8, valid stays 0.
4. enable=0, mode=001, serial_in=1 for 3 cycles -> out, fill, serial_out unchanged; then enable=1, mode=110 -> out=0, fill=0, full=0.
5. WIDTH=4, DEPTH=4, mode=010, feed 4'h1,4'h2,4'h3,4'h4 -> out=16'h1234, full=1; feed 4'h5 -> out=16'h2345, serial_out=4'h1, valid=1.
6. Mid-sequence reset during shifting (fill=5) -> next cycle all outputs 0; following shift gives fill=1.

Source files
------------

// File: rtl/universal_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : universal_shift_register
// Brief    : DEPTH-stage shift register of WIDTH-bit symbols. Each cycle it
//            can hold, shift, rotate, parallel-load or clear. It counts how
//            many stages hold valid data and flags when a shift ejects a
//            valid symbol.
// Revision : 1.0 - initial release
// ============================================================================
module universal_shift_register #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [2:0]             mode,
    input  logic [WIDTH-1:0]       serial_in,
    input  logic [DEPTH*WIDTH-1:0] parallel_in,
    output logic [DEPTH*WIDTH-1:0] out,
    output logic [WIDTH-1:0]       serial_out,
    output logic                   serial_out_valid,
    output logic [CW-1:0]          fill,
    output logic                   full
);

    localparam logic [2:0]    c_mode_hold   = 3'b000;
    localparam logic [2:0]    c_mode_shr    = 3'b001;
    localparam logic [2:0]    c_mode_shl    = 3'b010;
    localparam logic [2:0]    c_mode_rotr   = 3'b011;
    localparam logic [2:0]    c_mode_rotl   = 3'b100;
    localparam logic [2:0]    c_mode_load   = 3'b101;
    localparam logic [2:0]    c_mode_clear  = 3'b110;
    localparam logic [CW-1:0] c_fill_max    = CW'(DEPTH);
    localparam logic [CW-1:0] c_fill_one    = CW'(1);

    logic [DEPTH*WIDTH-1:0] r_out;
    logic [WIDTH-1:0]       r_serial_out;
    logic                   r_serial_out_valid;
    logic [CW-1:0]          r_fill;

    logic [DEPTH*WIDTH-1:0] w_out_next;
    logic [WIDTH-1:0]       w_serial_out_next;
    logic                   w_valid_next;
    logic [CW-1:0]          w_fill_next;
    logic                   w_full;
    logic [CW-1:0]          w_fill_inc;

    assign w_full     = (r_fill == c_fill_max);
    // Shift-in count saturates once every stage holds valid data.
    assign w_fill_inc = w_full ? r_fill : (r_fill + c_fill_one);

    // Next-state selection for the stage array, ejected symbol and fill count.
    always_comb begin
        w_out_next        = r_out;
        w_serial_out_next = r_serial_out;
        w_valid_next      = 1'b0;
        w_fill_next       = r_fill;
        if (enable) begin
            case (mode)
                c_mode_shr, c_mode_rotr: begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        w_out_next[i*WIDTH +: WIDTH] = r_out[(i+1)*WIDTH +: WIDTH];
                    end
                    if (mode == c_mode_shr) begin
                        w_out_next[(DEPTH-1)*WIDTH +: WIDTH] = serial_in;
                        w_serial_out_next = r_out[0 +: WIDTH];
                        w_valid_next      = w_full;
                        w_fill_next       = w_fill_inc;
                    end else begin
                        w_out_next[(DEPTH-1)*WIDTH +: WIDTH] = r_out[0 +: WIDTH];
                    end
                end
                c_mode_shl, c_mode_rotl: begin
                    for (int i = 1; i < DEPTH; i++) begin
                        w_out_next[i*WIDTH +: WIDTH] = r_out[(i-1)*WIDTH +: WIDTH];
                    end
                    if (mode == c_mode_shl) begin
                        w_out_next[0 +: WIDTH] = serial_in;
                        w_serial_out_next = r_out[(DEPTH-1)*WIDTH +: WIDTH];
                        w_valid_next      = w_full;
                        w_fill_next       = w_fill_inc;
                    end else begin
                        w_out_next[0 +: WIDTH] = r_out[(DEPTH-1)*WIDTH +: WIDTH];
                    end
                end
                c_mode_load: begin
                    w_out_next  = parallel_in;
                    w_fill_next = c_fill_max;
                end
                c_mode_clear: begin
                    w_out_next  = '0;
                    w_fill_next = '0;
                end
                c_mode_hold: begin
                    w_out_next = r_out;
                end
                default: begin
                    // Reserved encoding is treated as hold.
                    w_out_next = r_out;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out              <= '0;
            r_serial_out       <= '0;
            r_serial_out_valid <= 1'b0;
            r_fill             <= '0;
        end else begin
            r_out              <= w_out_next;
            r_serial_out       <= w_serial_out_next;
            r_serial_out_valid <= w_valid_next;
            r_fill             <= w_fill_next;
        end
    end

    assign out              = r_out;
    assign serial_out       = r_serial_out;
    assign serial_out_valid = r_serial_out_valid;
    assign fill             = r_fill;
    assign full             = w_full;

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_universal_shift_register
// Brief    : Directed checks of universal_shift_register in two shapes:
//            1-bit x 8 stages (instance a) and 4-bit x 4 stages (instance b).
// Revision : 1.0 - initial release
// ============================================================================
module tb_universal_shift_register;

    logic clk = 1'b0;
    logic reset = 1'b0;

    // Instance a: WIDTH=1, DEPTH=8
    logic       a_enable = 1'b0;
    logic [2:0] a_mode = 3'b000;
    logic       a_si = 1'b0;
    logic [7:0] a_pin = 8'h00;
    logic [7:0] a_out;
    logic       a_so;
    logic       a_sov;
    logic [3:0] a_fill;
    logic       a_full;

    // Instance b: WIDTH=4, DEPTH=4
    logic        b_enable = 1'b0;
    logic [2:0]  b_mode = 3'b000;
    logic [3:0]  b_si = 4'h0;
    logic [15:0] b_pin = 16'h0000;
    logic [15:0] b_out;
    logic [3:0]  b_so;
    logic        b_sov;
    logic [2:0]  b_fill;
    logic        b_full;

    int errors = 0;
    int checks = 0;

    universal_shift_register #(.WIDTH(1), .DEPTH(8)) u_a (
        .clk(clk), .reset(reset), .enable(a_enable), .mode(a_mode),
        .serial_in(a_si), .parallel_in(a_pin), .out(a_out),
        .serial_out(a_so), .serial_out_valid(a_sov), .fill(a_fill), .full(a_full)
    );

    universal_shift_register #(.WIDTH(4), .DEPTH(4)) u_b (
        .clk(clk), .reset(reset), .enable(b_enable), .mode(b_mode),
        .serial_in(b_si), .parallel_in(b_pin), .out(b_out),
        .serial_out(b_so), .serial_out_valid(b_sov), .fill(b_fill), .full(b_full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic a_shift(input logic bit_in);
        a_enable = 1'b1;
        a_mode   = 3'b001;
        a_si     = bit_in;
        tick();
    endtask

    task automatic b_shl(input logic [3:0] sym);
        b_enable = 1'b1;
        b_mode   = 3'b010;
        b_si     = sym;
        tick();
    endtask

    initial begin
        // 1. Reset dominates a load request
        reset = 1'b0;
        a_enable = 1'b1; a_mode = 3'b101; a_pin = 8'hFF;
        b_enable = 1'b1; b_mode = 3'b101; b_pin = 16'hFFFF;
        tick();
        check("rst_a_out",   a_out,  8'h00);
        check("rst_a_fill",  a_fill, 4'd0);
        check("rst_a_full",  a_full, 1'b0);
        check("rst_a_so",    a_so,   1'b0);
        check("rst_a_sov",   a_sov,  1'b0);
        check("rst_b_out",   b_out,  16'h0000);
        check("rst_b_fill",  b_fill, 3'd0);
        reset = 1'b1;
        b_enable = 1'b0; b_mode = 3'b000;

        // 2. Shift right, new bit enters MSB
        a_shift(1'b1); a_shift(1'b1); a_shift(1'b0); a_shift(1'b1);
        a_shift(1'b0); a_shift(1'b1); a_shift(1'b1);
        check("shr7_out",  a_out,  8'b11010110);
        check("shr7_fill", a_fill, 4'd7);
        check("shr7_full", a_full, 1'b0);
        a_shift(1'b0);
        check("shr8_out",  a_out,  8'b01101011);
        check("shr8_fill", a_fill, 4'd8);
        check("shr8_full", a_full, 1'b1);
        check("shr8_so",   a_so,   1'b0);
        check("shr8_sov",  a_sov,  1'b0);
        a_shift(1'b0);
        check("shr9_out",  a_out,  8'b00110101);
        check("shr9_fill", a_fill, 4'd8);
        check("shr9_so",   a_so,   1'b1);
        check("shr9_sov",  a_sov,  1'b1);

        // 3. Load and rotates
        a_mode = 3'b101; a_pin = 8'hA5;
        tick();
        check("load_out",  a_out,  8'hA5);
        check("load_fill", a_fill, 4'd8);
        check("load_sov",  a_sov,  1'b0);
        check("load_so",   a_so,   1'b1);
        a_mode = 3'b100;
        tick();
        check("rotl_out",  a_out,  8'h4B);
        check("rotl_sov",  a_sov,  1'b0);
        check("rotl_so",   a_so,   1'b1);
        a_mode = 3'b011;
        tick();
        check("rotr1_out", a_out,  8'hA5);
        tick();
        check("rotr2_out",  a_out,  8'hD2);
        check("rotr2_fill", a_fill, 4'd8);
        check("rotr2_sov",  a_sov,  1'b0);
        a_mode = 3'b111;
        tick();
        check("rsvd_out",  a_out,  8'hD2);
        check("rsvd_fill", a_fill, 4'd8);

        // 4. Enable low holds everything, then clear
        a_enable = 1'b0; a_mode = 3'b001; a_si = 1'b1;
        tick(); tick(); tick();
        check("dis_out",  a_out,  8'hD2);
        check("dis_fill", a_fill, 4'd8);
        check("dis_so",   a_so,   1'b1);
        check("dis_sov",  a_sov,  1'b0);
        a_enable = 1'b1; a_mode = 3'b110;
        tick();
        check("clr_out",  a_out,  8'h00);
        check("clr_fill", a_fill, 4'd0);
        check("clr_full", a_full, 1'b0);
        a_enable = 1'b0;

        // 5. Multi-bit shift left
        b_shl(4'h1); b_shl(4'h2); b_shl(4'h3); b_shl(4'h4);
        check("b4_out",  b_out,  16'h1234);
        check("b4_fill", b_fill, 3'd4);
        check("b4_full", b_full, 1'b1);
        check("b4_sov",  b_sov,  1'b0);
        b_shl(4'h5);
        check("b5_out", b_out, 16'h2345);
        check("b5_so",  b_so,  4'h1);
        check("b5_sov", b_sov, 1'b1);
        b_mode = 3'b000;
        tick();
        check("bhold_out", b_out, 16'h2345);
        check("bhold_so",  b_so,  4'h1);
        check("bhold_sov", b_sov, 1'b0);
        b_enable = 1'b0;

        // 6. Reset in the middle of shifting
        a_shift(1'b1); a_shift(1'b1); a_shift(1'b1); a_shift(1'b1); a_shift(1'b1);
        check("mid_out",  a_out,  8'hF8);
        check("mid_fill", a_fill, 4'd5);
        reset = 1'b0;
        tick();
        check("mrst_out",  a_out,  8'h00);
        check("mrst_fill", a_fill, 4'd0);
        check("mrst_so",   a_so,   1'b0);
        check("mrst_sov",  a_sov,  1'b0);
        check("mrst_b_out", b_out, 16'h0000);
        reset = 1'b1;
        a_shift(1'b1);
        check("post_out",  a_out,  8'h80);
        check("post_fill", a_fill, 4'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
